// File: rtl/tile_map_writer.sv
// -----------------------------------------------------------------------------
// tile_map_writer
//   Queues tile-map write requests and drains them into the tile map RAM
//   during vertical blanking, so the map never changes under the raster.
//
//   Optional feature macro: TILE_MAP_CLEAR_ON_RESET_EN
//     When defined, the block sweeps the whole map to texture 0 after reset
//     (CLEAR state) before accepting any request.
//
// Ports
//   pclk        in   pixel clock, all logic on the rising edge
//   reset       in   synchronous, active-high reset
//   req_valid   in   tile-write request present
//   req_ready   out  request accepted on an edge where valid && ready
//   req_col     in   [4:0] tile column
//   req_row     in   [3:0] tile row
//   req_tex     in   [3:0] texture number to store
//   vblank      in   high outside active video
//   map_we      out  map RAM write enable (registered)
//   map_addr    out  [8:0] map RAM address (registered)
//   map_din     out  [3:0] map RAM write data (registered)
//   fifo_level  out  [4:0] entries held in the request FIFO
//   drop_cnt    out  [7:0] out-of-range requests rejected, saturating
// -----------------------------------------------------------------------------
module tile_map_writer #(
  parameter int DEPTH = 8,
  parameter int COLS  = 20,
  parameter int ROWS  = 15
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_col,
  input  logic [3:0] req_row,
  input  logic [3:0] req_tex,
  input  logic       vblank,
  output logic       map_we,
  output logic [8:0] map_addr,
  output logic [3:0] map_din,
  output logic [4:0] fifo_level,
  output logic [7:0] drop_cnt
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_W = 5'(DEPTH);

`ifdef TILE_MAP_CLEAR_ON_RESET_EN
  localparam logic [8:0]  LAST_CELL = 9'(COLS * ROWS - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN} state_t;
`endif

  state_t        r_state;
  state_t        w_state_next;

  // Each FIFO entry is {map address, texture}.
  logic [12:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_level;
  logic [7:0]    r_drop;
  logic          r_live;     // low on the reset edge, high one edge later
  logic          r_map_we;
  logic [8:0]    r_map_addr;
  logic [3:0]    r_map_din;
`ifdef TILE_MAP_CLEAR_ON_RESET_EN
  logic [8:0]    r_clr_addr;
`endif

  logic          w_in_range;
  logic [8:0]    w_addr;
  logic          w_accept;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;

  assign w_in_range = (32'(req_col) < COLS) && (32'(req_row) < ROWS);
  assign w_addr     = 9'(32'(req_col) + COLS * 32'(req_row));

`ifdef TILE_MAP_CLEAR_ON_RESET_EN
  assign req_ready  = r_live && (r_state != ST_CLEAR) && (r_level < DEPTH_W);
`else
  assign req_ready  = r_live && (r_level < DEPTH_W);
`endif

  assign w_accept   = req_valid && req_ready;
  assign w_push     = w_accept && w_in_range;
  assign w_drop     = w_accept && !w_in_range;

  always_ff @(posedge pclk) begin
    if (reset) begin
`ifdef TILE_MAP_CLEAR_ON_RESET_EN
      r_state <= ST_CLEAR;
`else
      r_state <= ST_IDLE;
`endif
    end else begin
      r_state <= w_state_next;
    end
  end

  // The edge that leaves IDLE already pops, so every vblank cycle with data
  // queued produces a write. When the entry being popped is the last one
  // (and nothing arrives alongside it) the FSM stays in / returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE, ST_DRAIN: begin
        w_pop = vblank && (r_level != 5'd0);
        if (w_pop && !((r_level == 5'd1) && !w_push))
          w_state_next = ST_DRAIN;
        else
          w_state_next = ST_IDLE;
      end
`ifdef TILE_MAP_CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        if (r_clr_addr == LAST_CELL)
          w_state_next = ST_IDLE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FIFO storage: no reset, written on push, read registered on pop.
  always_ff @(posedge pclk) begin
    if (!reset && w_push)
      r_mem[r_wr_ptr] <= {w_addr, req_tex};
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= 5'd0;
      r_drop     <= 8'd0;
      r_live     <= 1'b0;
      r_map_we   <= 1'b0;
      r_map_addr <= 9'd0;
      r_map_din  <= 4'd0;
`ifdef TILE_MAP_CLEAR_ON_RESET_EN
      r_clr_addr <= 9'd0;
`endif
    end else begin
      r_live   <= 1'b1;
      r_map_we <= 1'b0;

      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;

      if (w_pop) begin
        r_map_we                <= 1'b1;
        {r_map_addr, r_map_din} <= r_mem[r_rd_ptr];
        r_rd_ptr                <= r_rd_ptr + 1'b1;
      end

`ifdef TILE_MAP_CLEAR_ON_RESET_EN
      if (r_state == ST_CLEAR) begin
        r_map_we   <= 1'b1;
        r_map_addr <= r_clr_addr;
        r_map_din  <= 4'd0;
        r_clr_addr <= r_clr_addr + 9'd1;
      end
`endif

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase

      if (w_drop && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;
    end
  end

  assign map_we     = r_map_we;
  assign map_addr   = r_map_addr;
  assign map_din    = r_map_din;
  assign fifo_level = r_level;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_tile_map_writer.sv
// -----------------------------------------------------------------------------
// tb_tile_map_writer
//   Self-checking bench for tile_map_writer. A reference model (expected
//   write order queue, expected map contents, drop counter) is built from
//   the request stream and compared against the writes seen on the map port.
//   Optional feature macro: TILE_MAP_CLEAR_ON_RESET_EN (enables clear test).
// -----------------------------------------------------------------------------
module tb_tile_map_writer;

  localparam int COLS  = 20;
  localparam int ROWS  = 15;
  localparam int DEPTH = 8;
  localparam int CELLS = COLS * ROWS;
`ifdef TILE_MAP_CLEAR_ON_RESET_EN
  localparam int CLR_WRITES = CELLS;
`else
  localparam int CLR_WRITES = 0;
`endif

  logic       pclk      = 1'b0;
  logic       reset     = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_col   = 5'd0;
  logic [3:0] req_row   = 4'd0;
  logic [3:0] req_tex   = 4'd0;
  logic       vblank    = 1'b0;
  logic       map_we;
  logic [8:0] map_addr;
  logic [3:0] map_din;
  logic [4:0] fifo_level;
  logic [7:0] drop_cnt;

  tile_map_writer #(.DEPTH(DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
    .pclk(pclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_col(req_col), .req_row(req_row), .req_tex(req_tex), .vblank(vblank),
    .map_we(map_we), .map_addr(map_addr), .map_din(map_din),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #5 pclk = ~pclk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          model_drop;
  logic [12:0] wr_q[$];     // writes observed on the map port
  logic [12:0] exp_q[$];    // writes the model expects, in order
  logic [3:0]  map_obs[CELLS];
  logic [3:0]  map_model[CELLS];

  always @(negedge pclk) begin
    if (map_we) begin
      wr_q.push_back({map_addr, map_din});
      if (int'(map_addr) < CELLS) map_obs[map_addr] <= map_din;
      $display("write addr=%0d din=%0d", map_addr, map_din);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [12:0] entry(int c, int r, int t);
    return {9'(c + COLS * r), 4'(t)};
  endfunction

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; vblank = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (CLR_WRITES + 3) tick();
    wr_q.delete(); exp_q.delete();
    model_drop = 0;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; req_valid = 1'b0; vblank = 1'b0;
    tick(); tick();
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop: got %0d expected 0", drop_cnt); end
    n_cmp++; if (map_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b expected 0", map_we); end
    n_cmp++; if (map_addr !== 9'd0) begin n_fail++; $display("FAIL rst_addr: got %0d expected 0", map_addr); end
    n_cmp++; if (map_din !== 4'd0) begin n_fail++; $display("FAIL rst_din: got %0d expected 0", map_din); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b expected 0", req_ready); end
    wr_q.delete();
    reset = 1'b0;
`ifdef TILE_MAP_CLEAR_ON_RESET_EN
    bad = 0;
    for (int i = 0; i < CELLS - 1; i++) begin
      tick();
      if (req_ready !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL clr_ready_low: got %0d cycles ready expected 0", bad); end
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready_after: got %0b expected 1", req_ready); end
    repeat (3) tick();
    n_cmp++; if (wr_q.size() != CELLS) begin n_fail++; $display("FAIL clr_count: got %0d expected %0d", wr_q.size(), CELLS); end
    bad = 0;
    for (int i = 0; i < CELLS && i < wr_q.size(); i++)
      if (wr_q[i] !== {9'(i), 4'd0}) bad++;
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL clr_order: got %0d wrong entries expected 0", bad); end
`else
    bad = 0;
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise: got %0b expected 1", req_ready); end
    n_cmp++; if (map_we !== 1'b0) begin n_fail++; $display("FAIL rst_we_after: got %0b expected 0", map_we); end
`endif
    wr_q.delete();
  endtask

  task automatic test_single();
    do_reset();
    req_col = 5'd3; req_row = 4'd2; req_tex = 4'd5; req_valid = 1'b1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b expected 1", req_ready); end
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    n_cmp++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL single_no_write: got %0d writes expected 0", wr_q.size()); end
    n_cmp++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", fifo_level); end
    vblank = 1'b1;
    tick();
    n_cmp++; if (map_we !== 1'b1 || map_addr !== 9'd43 || map_din !== 4'd5) begin
      n_fail++; $display("FAIL single_write: got we=%0b addr=%0d din=%0d expected we=1 addr=43 din=5", map_we, map_addr, map_din);
    end
    repeat (5) tick();
    n_cmp++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL single_once: got %0d writes expected 1", wr_q.size()); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL single_empty: got %0d expected 0", fifo_level); end
    vblank = 1'b0;
    tick();
  endtask

  task automatic test_full();
    int lvl, got, w;
    logic [12:0] e;
    do_reset();
    lvl = 0; got = 0; e = '0;
    while (got < 9) begin
      int c, r, t;
      c = $urandom_range(0, COLS - 1); r = $urandom_range(0, ROWS - 1); t = $urandom_range(0, 15);
      e = entry(c, r, t);
      req_col = 5'(c); req_row = 4'(r); req_tex = 4'(t); req_valid = 1'b1;
      n_cmp++; if (req_ready !== (lvl < DEPTH)) begin n_fail++; $display("FAIL full_ready[%0d]: got %0b expected %0b", got, req_ready, lvl < DEPTH); end
      if (lvl < DEPTH) begin
        tick(); lvl++; got++; exp_q.push_back(e);
      end else break;
    end
    n_cmp++; if (fifo_level !== 5'd8) begin n_fail++; $display("FAIL full_level: got %0d expected 8", fifo_level); end
    repeat (5) tick();
    n_cmp++; if (fifo_level !== 5'd8 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_stall: got level=%0d ready=%0b expected level=8 ready=0", fifo_level, req_ready);
    end
    n_cmp++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL full_no_write: got %0d expected 0", wr_q.size()); end
    vblank = 1'b1;
    w = 0;
    while (req_ready !== 1'b1 && w < 10) begin tick(); w++; end
    n_cmp++;
    if (w >= 10) begin
      n_fail++; $display("FAIL full_ready_timeout: got ready=0 after 10 cycles expected 1");
    end else begin
      tick(); exp_q.push_back(e);
    end
    req_valid = 1'b0;
    w = 0;
    while (fifo_level !== 5'd0 && w < 30) begin tick(); w++; end
    n_cmp++; if (w >= 30) begin n_fail++; $display("FAIL full_drain_timeout: got level=%0d expected 0", fifo_level); end
    repeat (2) tick();
    vblank = 1'b0;
    tick();
    n_cmp++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_cmp++; if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_order[%0d]: got %0h expected %0h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_drop();
    do_reset();
    req_col = 5'd20; req_row = 4'd0; req_tex = 4'd1; req_valid = 1'b1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready: got %0b expected 1", req_ready); end
    tick();
    req_col = 5'd0; req_row = 4'd15; req_tex = 4'd2;
    tick();
    req_valid = 1'b0;
    model_drop = 2;
    tick();
    n_cmp++; if (drop_cnt !== 8'(model_drop)) begin n_fail++; $display("FAIL drop_two: got %0d expected %0d", drop_cnt, model_drop); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL drop_level: got %0d expected 0", fifo_level); end
    vblank = 1'b1;
    repeat (3) tick();
    vblank = 1'b0;
    tick();
    n_cmp++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL drop_no_write: got %0d expected 0", wr_q.size()); end
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        req_col = 5'($urandom_range(COLS, 31)); req_row = 4'($urandom_range(0, 15));
      end else begin
        req_col = 5'($urandom_range(0, 31)); req_row = 4'd15;
      end
      req_tex = 4'($urandom_range(0, 15));
      tick();
      model_drop = (model_drop < 255) ? model_drop + 1 : 255;
      if (i == 99) begin
        n_cmp++; if (drop_cnt !== 8'(model_drop)) begin n_fail++; $display("FAIL drop_mid: got %0d expected %0d", drop_cnt, model_drop); end
      end
    end
    req_valid = 1'b0;
    tick();
    n_cmp++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d expected 255", drop_cnt); end
  endtask

  task automatic test_partial();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      int c, r, t;
      c = $urandom_range(0, COLS - 1); r = $urandom_range(0, ROWS - 1); t = $urandom_range(0, 15);
      req_col = 5'(c); req_row = 4'(r); req_tex = 4'(t); req_valid = 1'b1;
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL part_ready[%0d]: got %0b expected 1", i, req_ready); end
      tick();
      exp_q.push_back(entry(c, r, t));
    end
    req_valid = 1'b0;
    vblank = 1'b1;
    tick(); tick();
    vblank = 1'b0;
    repeat (3) tick();
    n_cmp++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL part_first_count: got %0d expected 2", wr_q.size()); end
    n_cmp++; if (fifo_level !== 5'd2) begin n_fail++; $display("FAIL part_level: got %0d expected 2", fifo_level); end
    vblank = 1'b1;
    repeat (6) tick();
    vblank = 1'b0;
    tick();
    n_cmp++; if (wr_q.size() != 4) begin n_fail++; $display("FAIL part_total: got %0d expected 4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      n_cmp++; if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL part_order[%0d]: got %0h expected %0h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      int c, r, t;
      c = $urandom_range(0, COLS - 1); r = $urandom_range(0, ROWS - 1); t = $urandom_range(0, 15);
      req_col = 5'(c); req_row = 4'(r); req_tex = 4'(t); req_valid = 1'b1;
      tick();
      exp_q.push_back(entry(c, r, t));
    end
    req_valid = 1'b0;
    vblank = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (map_we !== 1'b0) begin n_fail++; $display("FAIL rd_we: got %0b expected 0", map_we); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL rd_level: got %0d expected 0", fifo_level); end
    reset = 1'b0;
    repeat (CLR_WRITES + 10) tick();
    vblank = 1'b0;
    tick();
    n_cmp++; if (wr_q.size() != 1 + CLR_WRITES) begin n_fail++; $display("FAIL rd_no_more: got %0d writes expected %0d", wr_q.size(), 1 + CLR_WRITES); end
    n_cmp++; if (wr_q.size() > 0 && wr_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rd_first: got %0h expected %0h", wr_q[0], exp_q[0]); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL rd_level_after: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int a = 0; a < CELLS; a++) begin map_obs[a] = 4'd0; map_model[a] = 4'd0; end
    for (int round = 0; round < 6; round++) begin
      int n, w, bad;
      n = $urandom_range(3, 16);
      vblank = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        int c, r, t;
        if ($urandom_range(0, 4) == 0) begin
          c = $urandom_range(COLS, 31); r = $urandom_range(0, 15);
        end else if (round[0]) begin
          c = $urandom_range(COLS - 4, COLS - 1); r = $urandom_range(ROWS - 2, ROWS - 1);
        end else begin
          c = $urandom_range(0, COLS - 1); r = $urandom_range(0, ROWS - 1);
        end
        t = $urandom_range(0, 15);
        req_col = 5'(c); req_row = 4'(r); req_tex = 4'(t); req_valid = 1'b1;
        if (vblank == 1'b0 && exp_q.size() >= DEPTH) vblank = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin tick(); w++; end
        if (w >= 20) begin
          n_cmp++; n_fail++; $display("FAIL b2b_ready_timeout: got ready=0 expected 1");
        end else begin
          tick();
          if (c < COLS && r < ROWS) begin
            exp_q.push_back(entry(c, r, t));
            map_model[c + COLS * r] = 4'(t);
          end else begin
            model_drop = (model_drop < 255) ? model_drop + 1 : 255;
          end
        end
      end
      req_valid = 1'b0;
      vblank = 1'b1;
      w = 0;
      while (fifo_level !== 5'd0 && w < 40) begin tick(); w++; end
      n_cmp++; if (w >= 40) begin n_fail++; $display("FAIL b2b_drain_timeout: got level=%0d expected 0", fifo_level); end
      repeat (2) tick();
      vblank = 1'b0;
      tick();
      n_cmp++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", round, wr_q.size(), exp_q.size()); end
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
        if (wr_q[i] !== exp_q[i]) bad++;
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d out-of-order entries expected 0", round, bad); end
      bad = 0;
      for (int a = 0; a < CELLS; a++)
        if (map_obs[a] !== map_model[a]) bad++;
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL b2b_map[%0d]: got %0d differing cells expected 0", round, bad); end
      n_cmp++; if (drop_cnt !== 8'(model_drop)) begin n_fail++; $display("FAIL b2b_drop[%0d]: got %0d expected %0d", round, drop_cnt, model_drop); end
      wr_q.delete(); exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_drop();
    test_partial();
    test_reset_drain();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
